// File: rtl/cpe_operand_loader.sv
// Serial-to-lane operand loader for the CPE matrix accelerator: fills N weight and N activation
// lanes from a valid/ready word stream, pulses mStart, then waits for finalReady. Option: WEIGHT_REUSE_EN.
module cpe_operand_loader #(
    parameter int KERNEL_SIZE   = 3,
    parameter int AXI_BUS_WIDTH = 32,
    parameter int CNT_WIDTH     = 16,
    parameter int IDX_WIDTH     = $clog2(KERNEL_SIZE * KERNEL_SIZE)
) (
    input  logic                                                Clk,
    input  logic                                                Rst,
    input  logic                                                in_valid,
    output logic                                                in_ready,
    input  logic [AXI_BUS_WIDTH-1:0]                            in_data,
    input  logic                                                reload_w,
    input  logic                                                finalReady,
    output logic [KERNEL_SIZE*KERNEL_SIZE*AXI_BUS_WIDTH-1:0]    multiplier_input,
    output logic [KERNEL_SIZE*KERNEL_SIZE*AXI_BUS_WIDTH-1:0]    multiplicand_input,
    output logic [KERNEL_SIZE*KERNEL_SIZE-1:0]                  mStart,
    output logic                                                busy,
    output logic [CNT_WIDTH-1:0]                                windows_done
);

    localparam int N = KERNEL_SIZE * KERNEL_SIZE;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        LOAD_D,
        FIRE,
        WAIT
    } state_t;

    state_t                    state_q, state_d;
    logic [IDX_WIDTH-1:0]      idx_q;
    logic                      finalready_q;
    logic                      weights_valid_q;
    logic [N*AXI_BUS_WIDTH-1:0] mult_q;
    logic [N*AXI_BUS_WIDTH-1:0] mcand_q;
    logic [N-1:0]              mstart_q;
    logic [CNT_WIDTH-1:0]      windows_done_q;

    logic xfer;
    logic last_lane;
    logic completion;

    assign in_ready   = (state_q == LOAD_W) || (state_q == LOAD_D);
    assign xfer       = in_valid & in_ready;
    assign last_lane  = (idx_q == IDX_WIDTH'(N - 1));
    assign completion = (state_q == WAIT) & finalReady & ~finalready_q;

    assign busy               = (state_q != IDLE);
    assign mStart             = mstart_q;
    assign multiplier_input   = mult_q;
    assign multiplicand_input = mcand_q;
    assign windows_done       = windows_done_q;

`ifndef WEIGHT_REUSE_EN
    logic unused_reuse;
    assign unused_reuse = reload_w ^ weights_valid_q;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
`ifdef WEIGHT_REUSE_EN
                // Stationary weights: skip the weight phase when a valid set is already loaded.
                if (weights_valid_q && !reload_w) state_d = LOAD_D;
                else                              state_d = LOAD_W;
`else
                state_d = LOAD_W;
`endif
            end
            LOAD_W:  if (xfer && last_lane) state_d = LOAD_D;
            LOAD_D:  if (xfer && last_lane) state_d = FIRE;
            FIRE:    state_d = WAIT;
            WAIT:    if (completion) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q         <= IDLE;
            idx_q           <= '0;
            finalready_q    <= 1'b0;
            weights_valid_q <= 1'b0;
            mult_q          <= '0;
            mcand_q         <= '0;
            mstart_q        <= '0;
            windows_done_q  <= '0;
        end else begin
            state_q      <= state_d;
            finalready_q <= finalReady;
            // Registered so the pulse lines up with the FIRE cycle.
            mstart_q     <= (state_q == LOAD_D && xfer && last_lane) ? '1 : '0;

            if (xfer) begin
                idx_q <= last_lane ? '0 : idx_q + 1'b1;
                for (int i = 0; i < N; i++) begin
                    if (idx_q == IDX_WIDTH'(i)) begin
                        if (state_q == LOAD_W)
                            mult_q[i*AXI_BUS_WIDTH +: AXI_BUS_WIDTH] <= in_data;
                        else
                            mcand_q[i*AXI_BUS_WIDTH +: AXI_BUS_WIDTH] <= in_data;
                    end
                end
            end

            if (state_q == LOAD_W && xfer && last_lane)
                weights_valid_q <= 1'b1;

            if (completion)
                windows_done_q <= windows_done_q + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_cpe_operand_loader.sv
// Scoreboard bench for cpe_operand_loader: random word streams against a lane-array model;
// a monitor pops the expected lane contents on every mStart pulse.
module tb_cpe_operand_loader;

    localparam int KS = 3;
    localparam int N  = KS * KS;
    localparam int W  = 32;
    localparam int CW = 4;
    localparam int BW = N * W;
`ifdef WEIGHT_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    logic          Clk = 1'b0;
    logic          Rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          reload_w;
    logic          finalReady;
    logic [BW-1:0] mult_bus;
    logic [BW-1:0] mcand_bus;
    logic [N-1:0]  mStart;
    logic          busy;
    logic [CW-1:0] wdone;

    cpe_operand_loader #(
        .KERNEL_SIZE  (KS),
        .AXI_BUS_WIDTH(W),
        .CNT_WIDTH    (CW)
    ) dut (
        .Clk               (Clk),
        .Rst               (Rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_data           (in_data),
        .reload_w          (reload_w),
        .finalReady        (finalReady),
        .multiplier_input  (mult_bus),
        .multiplicand_input(mcand_bus),
        .mStart            (mStart),
        .busy              (busy),
        .windows_done      (wdone)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Reference model: what each lane should hold and how many windows have completed.
    logic [W-1:0]  m_w [N];
    logic [W-1:0]  m_a [N];
    bit            m_wv;
    logic [CW-1:0] m_wd;

    typedef struct {
        logic [BW-1:0] w;
        logic [BW-1:0] a;
        logic [CW-1:0] wd;
        int            fire_cyc;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] pack(input logic [W-1:0] l [N]);
        logic [BW-1:0] b;
        b = '0;
        for (int i = 0; i < N; i++) b[i*W +: W] = l[i];
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_w[i] = '0;
            m_a[i] = '0;
        end
        m_wv = 1'b0;
        m_wd = '0;
    endtask

    task automatic check_reset();
        chk("rst_in_ready", BW'(in_ready), BW'(0));
        chk("rst_mstart", BW'(mStart), BW'(0));
        chk("rst_busy", BW'(busy), BW'(0));
        chk("rst_mult", mult_bus, BW'(0));
        chk("rst_mcand", mcand_bus, BW'(0));
        chk("rst_windows_done", BW'(wdone), BW'(0));
    endtask

    // Monitor: every mStart pulse must match the oldest outstanding window.
    bit prev_ms = 1'b0;
    always @(negedge Clk) begin
        if (mStart !== '0) begin
            exp_t e;
            chk("mstart_one_cycle", BW'(prev_ms), BW'(0));
            chk("in_ready_in_fire", BW'(in_ready), BW'(0));
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_mstart: got %h at cycle %0d expected none", mStart, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("mstart_value", BW'(mStart), BW'({N{1'b1}}));
                chk("fire_cycle", BW'(cyc), BW'(e.fire_cyc));
                chk("weight_lanes", mult_bus, e.w);
                chk("activation_lanes", mcand_bus, e.a);
                chk("windows_done_at_fire", BW'(wdone), BW'(e.wd));
            end
        end
        prev_ms = (mStart !== '0);
    end

    // Called at a negedge; returns at the negedge right after the handshake edge.
    task automatic send_word(input logic [W-1:0] d, input bit gaps, input bit last);
        int guard = 0;
        if (gaps) begin
            while ($urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                @(negedge Clk);
            end
        end
        in_valid = 1'b1;
        in_data  = d;
        while (in_ready !== 1'b1) begin
            @(negedge Clk);
            guard++;
            if (guard > 200) begin
                checks++;
                errors++;
                $display("FAIL handshake_timeout: got in_ready=%b expected 1 within 200 cycles", in_ready);
                in_valid = 1'b0;
                return;
            end
        end
        if (last) exp_q.push_back('{pack(m_w), pack(m_a), m_wd, cyc + 1});
        @(negedge Clk);
        in_valid = 1'b0;
    endtask

    task automatic run_window(input bit seq, input bit gaps);
        bit need_w;
        need_w = !(REUSE && m_wv && !reload_w);
        if (need_w) begin
            for (int k = 0; k < N; k++) begin
                m_w[k] = seq ? W'(k + 1) : W'($urandom);
                send_word(m_w[k], gaps, 1'b0);
            end
            m_wv = 1'b1;
        end
        for (int k = 0; k < N; k++) begin
            m_a[k] = seq ? W'(k + 10) : W'($urandom);
            send_word(m_a[k], gaps, k == N - 1);
        end
    endtask

    // Entered at the FIRE negedge (or later, still in WAIT); holds finalReady for 'hold' cycles.
    task automatic complete_window(input int hold);
        @(negedge Clk);
        repeat (2) begin
            chk("wait_in_ready", BW'(in_ready), BW'(0));
            chk("wait_busy", BW'(busy), BW'(1));
            chk("wait_mult_stable", mult_bus, pack(m_w));
            chk("wait_mcand_stable", mcand_bus, pack(m_a));
            @(negedge Clk);
        end
        finalReady = 1'b1;
        m_wd++;
        @(negedge Clk);
        chk("idle_in_ready", BW'(in_ready), BW'(0));
        chk("idle_busy", BW'(busy), BW'(0));
        @(negedge Clk);
        chk("reload_in_ready", BW'(in_ready), BW'(1));
        repeat (hold - 2) @(negedge Clk);
        chk("windows_done", BW'(wdone), BW'(m_wd));
        finalReady = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        reload_w   = 1'b1;
        finalReady = 1'b0;
        model_reset();
        repeat (3) @(negedge Clk);
        check_reset();
        Rst = 1'b0;

        // Sequential pattern, back-to-back, then a 5-cycle finalReady hold.
        run_window(1'b1, 1'b0);
        complete_window(5);

        // Same pattern with random valid gaps.
        run_window(1'b1, 1'b1);
        reload_w = 1'b0;
        complete_window(2);

        // Weight reuse (9 words when enabled), then forced reload (18 words).
        run_window(1'b0, 1'b0);
        reload_w = 1'b1;
        complete_window(3);
        run_window(1'b0, 1'b1);

        // finalReady rising during FIRE must not complete the window.
        finalReady = 1'b1;
        repeat (3) begin
            @(negedge Clk);
            chk("fire_edge_busy", BW'(busy), BW'(1));
            chk("fire_edge_windows_done", BW'(wdone), BW'(m_wd));
        end
        finalReady = 1'b0;
        @(negedge Clk);
        complete_window(2);

        // Reset after four weight words discards the partial load.
        for (int k = 0; k < 4; k++) send_word(W'($urandom), 1'b0, 1'b0);
        Rst = 1'b1;
        @(negedge Clk);
        check_reset();
        model_reset();
        Rst = 1'b0;
        run_window(1'b0, 1'b1);
        complete_window(2);

        // Random windows; enough completions to wrap the narrow counter.
        for (int i = 0; i < 18; i++) begin
            run_window(1'b0, i[0]);
            reload_w = 1'($urandom_range(0, 1));
            complete_window(2 + (i % 3));
        end

        repeat (3) @(negedge Clk);
        chk("scoreboard_drained", BW'(exp_q.size()), BW'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
